// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode,
// execute, memory access and writeback, plus a sticky illegal-op flag.
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [2:0]         alu_f,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  state_t state_reg, state_next;
  logic   illegal_reg, illegal_next;
  logic   funct_legal;
  logic [2:0] funct_alu;
  logic   decode_bad;
  state_t out_state;

  // Map an R-type funct onto the ALU operation code and flag unsupported ones.
  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = 3'b010;
    case (funct)
      FN_ADD:  funct_alu = 3'b010;
      FN_SUB:  funct_alu = 3'b110;
      FN_AND:  funct_alu = 3'b000;
      FN_OR:   funct_alu = 3'b001;
      FN_SLT:  funct_alu = 3'b111;
      default: funct_legal = 1'b0;
    endcase
  end

  // Next-state selection and sticky illegal-op detection on leaving DECODE.
  always_comb begin
    state_next = S_FETCH;
    decode_bad = 1'b0;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE: begin
            if (funct_legal) state_next = S_EXECUTE;
            else             decode_bad = 1'b1;
          end
          OP_BEQ:  state_next = S_BRANCH;
          OP_ADDI: state_next = S_ADDIEX;
          OP_J:    state_next = S_JUMP;
          default: decode_bad = 1'b1;
        endcase
      end
      S_MEMADR:  state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = S_MEMWB;
      S_EXECUTE: state_next = S_ALUWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
    illegal_next = illegal_reg | decode_bad;
  end

  // State and illegal flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= S_FETCH;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
    end
  end

  // While reset is asserted the outputs look like FETCH with writes masked.
  assign out_state = reset_n ? state_reg : S_FETCH;

  // Moore output decode from the (reset-masked) state; only BRANCH's pc_en
  // looks at the live zero flag.
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_f      = 3'b010;
    case (out_state)
      S_FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_en     = 1'b1;
      end
      S_DECODE:  alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_f     = funct_alu;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_f     = 3'b110;
        pc_src    = 2'b01;
        pc_en     = zero;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB:  reg_write = 1'b1;
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    if (!reset_n) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign illegal_op = illegal_reg;
  assign state      = STATE_W'(out_state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: hand-written instruction
// table, reset corner cases, and random instructions against a model that
// predicts per-instruction behaviour from the instruction class.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_f;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  logic ill_model = 1'b0;

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_f(alu_f), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Expected per-instruction summary: cycle count, visited state codes
  // packed 4 bits each, counts of active cycles, and the third-cycle
  // ALU controls.
  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    int          cycles;
    logic [31:0] seq;
    int          rw;
    int          mw;
    int          pcen;
    int          asa;
    int          iordc;
    logic [2:0]  aluf;
    logic [1:0]  bsel;
    logic [1:0]  psrc;
    logic        rdst;
    logic        m2r;
    logic        illegal;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: what one instruction should do, by class.
  function automatic vec_t ref_model(input logic [5:0] o, input logic [5:0] f, input logic z);
    vec_t v;
    v = '{default: 0};
    v.op = o; v.funct = f; v.zero = z;
    v.pcen = 1; v.aluf = 3'b010;
    v.cycles = 2; v.seq = 32'h01; v.illegal = 1'b1;
    case (o)
      6'b100011: begin v.illegal = 0; v.cycles = 5; v.seq = 32'h01234; v.rw = 1; v.m2r = 1;
                       v.asa = 1; v.iordc = 1; v.bsel = 2'b10; end
      6'b101011: begin v.illegal = 0; v.cycles = 4; v.seq = 32'h0125; v.mw = 1;
                       v.asa = 1; v.iordc = 1; v.bsel = 2'b10; end
      6'b000000: begin
        if (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) begin
          v.illegal = 0; v.cycles = 4; v.seq = 32'h0167; v.rw = 1; v.rdst = 1; v.asa = 1;
          case (f)
            6'b100000: v.aluf = 3'b010;
            6'b100010: v.aluf = 3'b110;
            6'b100100: v.aluf = 3'b000;
            6'b100101: v.aluf = 3'b001;
            default:   v.aluf = 3'b111;
          endcase
        end
      end
      6'b000100: begin v.illegal = 0; v.cycles = 3; v.seq = 32'h018; v.asa = 1;
                       v.aluf = 3'b110; v.psrc = 2'b01; v.pcen = 1 + int'(z); end
      6'b001000: begin v.illegal = 0; v.cycles = 4; v.seq = 32'h019A; v.rw = 1;
                       v.asa = 1; v.bsel = 2'b10; end
      6'b000010: begin v.illegal = 0; v.cycles = 3; v.seq = 32'h01B; v.pcen = 2;
                       v.psrc = 2'b10; end
      default: ;
    endcase
    return v;
  endfunction

  // Run one instruction starting in FETCH, tally the outputs cycle by cycle
  // and compare against the expected record.
  task automatic run_instr(input vec_t v);
    logic [31:0] seq = 0;
    int n = 0, rw = 0, mw = 0, pcen = 0, irw = 0, asa = 0, iordc = 0;
    logic rdst = 0, m2r = 0, done = 0;
    logic [2:0] aluf = 3'b010;
    logic [1:0] bsel = 0, psrc = 0, bdec = 0;
    op = v.op; funct = v.funct; zero = v.zero;
    while (!done && n < 8) begin
      @(negedge clk);
      seq = (seq << 4) | 32'(state);
      if (reg_write) begin rw++; rdst = reg_dst; m2r = mem_to_reg; end
      if (mem_write) mw++;
      if (pc_en)     pcen++;
      if (ir_write)  irw++;
      if (alu_src_a) asa++;
      if (iord)      iordc++;
      if (n == 1) bdec = alu_src_b;
      if (n == 2) begin aluf = alu_f; bsel = alu_src_b; psrc = pc_src; end
      n++;
      @(posedge clk); #1;
      if (state == 4'd0) done = 1;
    end
    $display("instr op=%b funct=%b zero=%b cycles=%0d seq=%0h illegal_op=%b",
             v.op, v.funct, v.zero, n, seq, illegal_op);
    if (!done) chk("return_to_fetch_timeout", 32'(done), 32'd1);
    chk("cycles", n, v.cycles);
    chk("state_seq", seq, v.seq);
    chk("reg_write_cnt", rw, v.rw);
    chk("mem_write_cnt", mw, v.mw);
    chk("pc_en_cnt", pcen, v.pcen);
    chk("ir_write_cnt", irw, 1);
    chk("alu_src_a_cnt", asa, v.asa);
    chk("iord_cnt", iordc, v.iordc);
    chk("reg_dst", 32'(rdst), 32'(v.rdst));
    chk("mem_to_reg", 32'(m2r), 32'(v.m2r));
    chk("decode_alu_src_b", 32'(bdec), 32'h3);
    if (v.cycles >= 3) begin
      chk("exec_alu_f", 32'(aluf), 32'(v.aluf));
      chk("exec_alu_src_b", 32'(bsel), 32'(v.bsel));
      chk("exec_pc_src", 32'(psrc), 32'(v.psrc));
    end
    if (v.illegal) ill_model = 1'b1;
    chk("illegal_op", 32'(illegal_op), 32'(ill_model));
  endtask

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    //            op         funct      z  cyc seq       rw mw pc asa io aluf    bsel   psrc   rd m2r ill
    tbl[0] = '{6'b100011, 6'b000000, 0, 5, 32'h01234, 1, 0, 1, 1, 1, 3'b010, 2'b10, 2'b00, 0, 1, 0};
    tbl[1] = '{6'b000000, 6'b100010, 0, 4, 32'h0167,  1, 0, 1, 1, 0, 3'b110, 2'b00, 2'b00, 1, 0, 0};
    tbl[2] = '{6'b000000, 6'b101010, 1, 4, 32'h0167,  1, 0, 1, 1, 0, 3'b111, 2'b00, 2'b00, 1, 0, 0};
    tbl[3] = '{6'b000100, 6'b000000, 1, 3, 32'h018,   0, 0, 2, 1, 0, 3'b110, 2'b00, 2'b01, 0, 0, 0};
    tbl[4] = '{6'b000100, 6'b000000, 0, 3, 32'h018,   0, 0, 1, 1, 0, 3'b110, 2'b00, 2'b01, 0, 0, 0};
    tbl[5] = '{6'b000010, 6'b000000, 0, 3, 32'h01B,   0, 0, 2, 0, 0, 3'b010, 2'b00, 2'b10, 0, 0, 0};
    tbl[6] = '{6'b101011, 6'b000000, 0, 4, 32'h0125,  0, 1, 1, 1, 1, 3'b010, 2'b10, 2'b00, 0, 0, 0};
    tbl[7] = '{6'b111111, 6'b000000, 0, 2, 32'h01,    0, 0, 1, 0, 0, 3'b010, 2'b00, 2'b00, 0, 0, 1};
    tbl[8] = '{6'b000000, 6'b000000, 0, 2, 32'h01,    0, 0, 1, 0, 0, 3'b010, 2'b00, 2'b00, 0, 0, 1};
    tbl[9] = '{6'b001000, 6'b000000, 0, 4, 32'h019A,  1, 0, 1, 1, 0, 3'b010, 2'b10, 2'b00, 0, 0, 0};

    // Reset held for three cycles: FETCH look with every write masked.
    reset_n = 1'b0; op = 6'b000010; funct = 6'b0; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      $display("reset cycle %0d state=%0d", i, state);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_writes", {pc_en, ir_write, mem_write, reg_write}, 32'd0);
      chk("rst_alu_src_b", 32'(alu_src_b), 32'h1);
      chk("rst_alu_f", 32'(alu_f), 32'h2);
    end
    chk("rst_illegal_op", 32'(illegal_op), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    $display("post-reset fetch ir_write=%b pc_en=%b", ir_write, pc_en);
    chk("fetch_ir_write", 32'(ir_write), 32'd1);
    chk("fetch_pc_en", 32'(pc_en), 32'd1);
    chk("fetch_alu_src_b", 32'(alu_src_b), 32'h1);
    chk("fetch_alu_f", 32'(alu_f), 32'h2);
    // Let the jump held on op finish, back in FETCH.
    for (int i = 0; i < 8 && !(i > 0 && state == 4'd0); i++) begin
      @(posedge clk); #1;
    end
    chk("prefetch_state", 32'(state), 32'd0);

    for (int i = 0; i < 10; i++) run_instr(tbl[i]);

    // Reset dropped in MEMADR of a store: no write, FETCH afterwards,
    // illegal flag cleared.
    op = 6'b101011; funct = 6'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sw_in_memadr", 32'(state), 32'd2);
    chk("illegal_before_reset", 32'(illegal_op), 32'(ill_model));
    reset_n = 1'b0;
    @(negedge clk);
    $display("reset in memadr state=%0d mem_write=%b", state, mem_write);
    chk("midrst_mem_write", 32'(mem_write), 32'd0);
    chk("midrst_state", 32'(state), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    ill_model = 1'b0;
    chk("postrst_state", 32'(state), 32'd0);
    chk("postrst_illegal", 32'(illegal_op), 32'd0);

    // Random instructions checked against the model.
    for (int i = 0; i < 60; i++) begin
      logic [5:0] o, f;
      logic [5:0] fl[5];
      fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      case ($urandom_range(0, 7))
        0: o = 6'b100011;
        1: o = 6'b101011;
        2, 3: o = 6'b000000;
        4: o = 6'b000100;
        5: o = 6'b001000;
        6: o = 6'b000010;
        default: o = 6'($urandom);
      endcase
      f = ($urandom_range(0, 3) != 0) ? fl[$urandom_range(0, 4)] : 6'($urandom);
      run_instr(ref_model(o, f, 1'($urandom)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
